// File: rtl/fft_pkg.sv
// Shared types and width helpers for the spectrum-path frame generator.
package fft_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CAPTURE,
        PAD
    } state_t;

    localparam int FRAME_LEN_DEF = 1024;

    function automatic int cnt_w(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

    function automatic int ptr_w(input int depth);
        return (depth > 2) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/fft_frame_fifo.sv
// First-word fall-through FIFO carrying {sample, last} to the output port.
import fft_pkg::*;

module fft_frame_fifo #(
    parameter int W     = 17,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         wr_en,
    input  logic [W-1:0] wr_data,
    input  logic         rd_en,
    output logic [W-1:0] rd_data,
    output logic         full,
    output logic         empty
);

    localparam int PW = ptr_w(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [PW:0]  wr_ptr;
    logic [PW:0]  rd_ptr;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[PW] != rd_ptr[PW]) &&
                   (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);

    // Empty head reads as zero so the port idles at 0 out of reset.
    assign rd_data = empty ? '0 : mem[rd_ptr[PW-1:0]];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en && !full)
                wr_ptr <= wr_ptr + (PW+1)'(1);
            if (rd_en && !empty)
                rd_ptr <= rd_ptr + (PW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en && !full)
            mem[wr_ptr[PW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/fft_frame_gen.sv
// ADC stream to fixed-length AXI-Stream frames, zero-padded on overrun.
import fft_pkg::*;

module fft_frame_gen #(
    parameter int DW         = 16,
    parameter int FRAME_LEN  = FRAME_LEN_DEF,
    parameter int DEC_W      = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [DW-1:0]    adc_data,
    input  logic             adc_valid,
    input  logic [DEC_W-1:0] dec_ratio,
    input  logic             arm,
    input  logic             continuous,
    input  logic             clear_ovr,
    output logic [DW-1:0]    tdata_m,
    output logic             tvalid_m,
    output logic             tlast_m,
    input  logic             tready_m,
    output logic             busy,
    output logic             overrun,
    output logic [15:0]      frame_cnt
);

    localparam int CW = cnt_w(FRAME_LEN);
    localparam logic [CW-1:0] LAST_IDX = CW'(FRAME_LEN - 1);

    state_t           state, state_d;
    logic [CW-1:0]    cnt, cnt_d;
    logic [DEC_W-1:0] dec_cnt, dec_cnt_d;
    logic [DEC_W-1:0] ratio_r, ratio_d;
    logic [DEC_W-1:0] ratio_in, dec_inc;
    logic [15:0]      frame_cnt_d;
    logic             overrun_d;
    logic             push, drop, keep, is_last;
    logic [DW-1:0]    push_data;
    logic             full, empty;
    logic [DW:0]      head;

    assign ratio_in = (dec_ratio == '0) ? DEC_W'(1) : dec_ratio;
    assign is_last  = (cnt == LAST_IDX);
    assign keep     = adc_valid && (dec_cnt == '0);
    assign dec_inc  = dec_cnt + DEC_W'(1);

    always_comb begin
        state_d     = state;
        cnt_d       = cnt;
        dec_cnt_d   = dec_cnt;
        ratio_d     = ratio_r;
        frame_cnt_d = frame_cnt;
        push        = 1'b0;
        push_data   = '0;
        drop        = 1'b0;
        unique case (state)
            IDLE: begin
                if (arm || continuous) begin
                    state_d   = CAPTURE;
                    cnt_d     = '0;
                    dec_cnt_d = '0;
                    ratio_d   = ratio_in;
                end
            end
            CAPTURE: begin
                if (adc_valid)
                    dec_cnt_d = (dec_inc == ratio_r) ? '0 : dec_inc;
                if (keep && !full) begin
                    push      = 1'b1;
                    push_data = adc_data;
                    cnt_d     = cnt + CW'(1);
                end else if (keep) begin
                    drop    = 1'b1;
                    state_d = PAD;
                end
            end
            PAD: begin
                if (!full) begin
                    push  = 1'b1;
                    cnt_d = cnt + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        // Frame end overrides the per-sample counter updates above.
        if (push && is_last) begin
            frame_cnt_d = frame_cnt + 16'd1;
            cnt_d       = '0;
            dec_cnt_d   = '0;
            if (continuous) begin
                state_d = CAPTURE;
                ratio_d = ratio_in;
            end else begin
                state_d = IDLE;
            end
        end
        overrun_d = drop | (overrun & ~clear_ovr);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= IDLE;
            cnt       <= '0;
            dec_cnt   <= '0;
            ratio_r   <= DEC_W'(1);
            frame_cnt <= '0;
            overrun   <= 1'b0;
        end else begin
            state     <= state_d;
            cnt       <= cnt_d;
            dec_cnt   <= dec_cnt_d;
            ratio_r   <= ratio_d;
            frame_cnt <= frame_cnt_d;
            overrun   <= overrun_d;
        end
    end

    fft_frame_fifo #(
        .W     (DW + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .wr_en   (push),
        .wr_data ({push_data, is_last}),
        .rd_en   (tready_m),
        .rd_data (head),
        .full    (full),
        .empty   (empty)
    );

    assign tvalid_m = !empty;
    assign tdata_m  = head[DW:1];
    assign tlast_m  = head[0];
    assign busy     = (state != IDLE);

endmodule
